ni_inject_arbiter: RTL and testbench

Packet-level injection arbiter that shares one network output link between the cast send buffer and the gather send buffer of a network interface. It grants whole packets (HEAD through TAIL, wormhole style), alternates between the two sources round-robin, and gates every flit with a downstream credit counter replenished by the receiver's credit-update pulse. It sits between the two FWFT send FIFOs (with occupancy counts) and the router local input port.

---
 rtl/ni_inject_arbiter.sv | 156 +++++++++++++++
 tb/tb_ni_inject_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_inject_arbiter.sv
// ============================================================================
// ni_inject_arbiter : packet-level round-robin injection arbiter, cast/gather
// send FIFOs onto one credit-gated router link. Option: NI_INJ_CUT_THROUGH_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef DW
`define DW 16
`endif
`ifndef PKT_LEN
`define PKT_LEN 4
`endif
`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef TAIL
`define TAIL 2'b10
`endif

module ni_inject_arbiter #(
  parameter int DW         = `DW,
  parameter int PKT_LEN    = `PKT_LEN,
  parameter int CREDIT_MAX = 16,
  parameter int CNT_W      = 8,
  localparam int CW        = $clog2(CREDIT_MAX + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             c_valid_i,
  input  logic [DW-1:0]    c_data_i,
  input  logic [CNT_W-1:0] c_cnt_i,
  output logic             c_ready_o,
  input  logic             g_valid_i,
  input  logic [DW-1:0]    g_data_i,
  input  logic [CNT_W-1:0] g_cnt_i,
  output logic             g_ready_o,
  output logic             valid_o,
  output logic [DW-1:0]    data_o,
  input  logic             ready_i,
  input  logic             credit_upd_i,
  output logic [1:0]       grant_o,
  output logic [CW-1:0]    credit_cnt_o,
  output logic             credit_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND_C = 2'd1,
    ST_SEND_G = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_CRED_MAX = CW'(CREDIT_MAX);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_last_g;
  logic            w_last_g_nxt;
  logic [CW-1:0]   r_cred;
  logic            r_cred_err;
  logic            w_cred_ok;
  logic            w_xfer;
  logic            w_occ_c;
  logic            w_occ_g;
  logic            w_elig_c;
  logic            w_elig_g;
  logic [1:0]      w_type_c;
  logic [1:0]      w_type_g;

  assign w_type_c  = c_data_i[DW-1:DW-2];
  assign w_type_g  = g_data_i[DW-1:DW-2];
  assign w_cred_ok = (r_cred != '0);

`ifdef NI_INJ_CUT_THROUGH_EN
  assign w_occ_c = 1'b1;
  assign w_occ_g = 1'b1;
`else
  // Only start a packet once it is fully buffered so it never bubbles mid-flight.
  assign w_occ_c = (c_cnt_i >= CNT_W'(PKT_LEN));
  assign w_occ_g = (g_cnt_i >= CNT_W'(PKT_LEN));
`endif

  assign w_elig_c = c_valid_i && (w_type_c == `HEAD) && w_occ_c;
  assign w_elig_g = g_valid_i && (w_type_g == `HEAD) && w_occ_g;

  always_comb begin
    w_state_nxt  = r_state;
    w_last_g_nxt = r_last_g;
    valid_o      = 1'b0;
    data_o       = c_data_i;
    c_ready_o    = 1'b0;
    g_ready_o    = 1'b0;
    grant_o      = 2'b00;
    w_xfer       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_elig_c && (r_last_g || !w_elig_g)) begin
          w_state_nxt  = ST_SEND_C;
          w_last_g_nxt = 1'b0;
        end else if (w_elig_g) begin
          w_state_nxt  = ST_SEND_G;
          w_last_g_nxt = 1'b1;
        end
      end
      ST_SEND_C: begin
        grant_o   = 2'b01;
        valid_o   = c_valid_i && w_cred_ok;
        c_ready_o = valid_o && ready_i;
        w_xfer    = c_ready_o;
        if (w_xfer && (w_type_c == `TAIL))
          w_state_nxt = ST_IDLE;
      end
      ST_SEND_G: begin
        grant_o   = 2'b10;
        valid_o   = g_valid_i && w_cred_ok;
        data_o    = g_data_i;
        g_ready_o = valid_o && ready_i;
        w_xfer    = g_ready_o;
        if (w_xfer && (w_type_g == `TAIL))
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_last_g <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_last_g <= w_last_g_nxt;
    end
  end

  // A transfer and a returned credit in the same cycle cancel out.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cred     <= C_CRED_MAX;
      r_cred_err <= 1'b0;
    end else if (w_xfer && !credit_upd_i) begin
      r_cred <= r_cred - 1'b1;
    end else if (!w_xfer && credit_upd_i) begin
      if (r_cred == C_CRED_MAX)
        r_cred_err <= 1'b1;
      else
        r_cred <= r_cred + 1'b1;
    end
  end

  assign credit_cnt_o = r_cred;
  assign credit_err_o = r_cred_err;

endmodule

`default_nettype wire

// File: tb/tb_ni_inject_arbiter.sv
// ============================================================================
// tb_ni_inject_arbiter : directed self-checking bench for ni_inject_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef TAIL
`define TAIL 2'b10
`endif

module tb_ni_inject_arbiter;

  localparam int DW = 16;
  localparam int PKT = 4;
  localparam logic [1:0] C_HD = `HEAD;
  localparam logic [1:0] C_TL = `TAIL;
  localparam logic [1:0] C_BD = 2'b00;

  logic          clk;
  logic          rstn;
  logic          c_valid_i, g_valid_i, c_ready_o, g_ready_o;
  logic [DW-1:0] c_data_i, g_data_i, data_o;
  logic [7:0]    c_cnt_i, g_cnt_i;
  logic          valid_o, ready_i, credit_upd_i, credit_err_o;
  logic [1:0]    grant_o;
  logic [4:0]    credit_cnt_o;

  // second instance with a tiny credit pool, cast source only
  logic          s_c_valid, s_c_ready, s_g_ready, s_valid, s_err, s_upd;
  logic [DW-1:0] s_c_data, s_data, s_g_data;
  logic [7:0]    s_c_cnt, s_g_cnt;
  logic [1:0]    s_grant, s_cred;
  logic          s_g_valid;

  logic [DW-1:0] cq[$];
  logic [DW-1:0] gq[$];
  int            total = 0;
  int            bad = 0;
  int            si = 0;
  logic          pc, pg, ps;

  ni_inject_arbiter #(.DW(DW), .PKT_LEN(PKT), .CREDIT_MAX(16), .CNT_W(8)) u_dut (
    .clk(clk), .rstn(rstn),
    .c_valid_i(c_valid_i), .c_data_i(c_data_i), .c_cnt_i(c_cnt_i), .c_ready_o(c_ready_o),
    .g_valid_i(g_valid_i), .g_data_i(g_data_i), .g_cnt_i(g_cnt_i), .g_ready_o(g_ready_o),
    .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i), .credit_upd_i(credit_upd_i),
    .grant_o(grant_o), .credit_cnt_o(credit_cnt_o), .credit_err_o(credit_err_o)
  );

  ni_inject_arbiter #(.DW(DW), .PKT_LEN(PKT), .CREDIT_MAX(2), .CNT_W(8)) u_small (
    .clk(clk), .rstn(rstn),
    .c_valid_i(s_c_valid), .c_data_i(s_c_data), .c_cnt_i(s_c_cnt), .c_ready_o(s_c_ready),
    .g_valid_i(s_g_valid), .g_data_i(s_g_data), .g_cnt_i(s_g_cnt), .g_ready_o(s_g_ready),
    .valid_o(s_valid), .data_o(s_data), .ready_i(1'b1), .credit_upd_i(s_upd),
    .grant_o(s_grant), .credit_cnt_o(s_cred), .credit_err_o(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] flit(input int k, input int id);
    logic [1:0] t;
    t = (k == 0) ? C_HD : (k == PKT - 1) ? C_TL : C_BD;
    return {t, 8'(id), 6'(k)};
  endfunction

  task automatic drive();
    c_valid_i = (cq.size() != 0);
    c_data_i  = (cq.size() != 0) ? cq[0] : '0;
    c_cnt_i   = 8'(cq.size());
    g_valid_i = (gq.size() != 0);
    g_data_i  = (gq.size() != 0) ? gq[0] : '0;
    g_cnt_i   = 8'(gq.size());
  endtask

  task automatic push_c(input int id, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) cq.push_back(flit(k, id));
    drive();
    #1;
  endtask

  task automatic push_g(input int id, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) gq.push_back(flit(k, id));
    drive();
    #1;
  endtask

  // Pops follow the pre-edge ready outputs, like a real FWFT FIFO.
  task automatic step();
    @(negedge clk);
    pc = c_ready_o;
    pg = g_ready_o;
    ps = s_c_ready;
    @(posedge clk);
    #1;
    if (pc) cq.delete(0);
    if (pg) gq.delete(0);
    if (ps && si < PKT - 1) begin
      si++;
      s_c_data = flit(si, 8);
    end
    drive();
    #1;
  endtask

  initial begin
    rstn = 1'b0; ready_i = 1'b1; credit_upd_i = 1'b0;
    s_c_valid = 1'b0; s_c_data = '0; s_c_cnt = '0; s_upd = 1'b0;
    s_g_valid = 1'b0; s_g_data = '0; s_g_cnt = '0;
    drive();
    #12;
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_cred", 32'(credit_cnt_o), 32'd16);
    chk("rst_err", 32'(credit_err_o), 32'd0);
    chk("rst_ready", 32'({c_ready_o, g_ready_o}), 32'd0);

    // single cast packet, with a one-cycle ready_i stall on the head
    step();
    rstn = 1'b1;
    push_c(1, 0, 3);
    chk("b_idle_grant", 32'(grant_o), 32'd0);
    step();
    chk("b_grant", 32'(grant_o), 32'd1);
    ready_i = 1'b0;
    #1;
    chk("b_stall_valid", 32'(valid_o), 32'd1);
    chk("b_stall_ready", 32'(c_ready_o), 32'd0);
    step();
    ready_i = 1'b1;
    #1;
    for (int k = 0; k < PKT; k++) begin
      chk("b_valid", 32'(valid_o), 32'd1);
      chk("b_data", 32'(data_o), 32'(flit(k, 1)));
      step();
    end
    chk("b_end_grant", 32'(grant_o), 32'd0);
    chk("b_end_valid", 32'(valid_o), 32'd0);
    chk("b_cred", 32'(credit_cnt_o), 32'd12);

    // both sources loaded from reset: cast, gather, cast with one bubble each
    rstn = 1'b0;
    #1;
    cq.delete(); gq.delete();
    push_c(11, 0, 3); push_c(13, 0, 3); push_g(12, 0, 3);
    step();
    rstn = 1'b1;
    #1;
    for (int c = 0; c < 15; c++) begin
      if (c == 0 || c == 5 || c == 10) begin
        chk("c_bubble_valid", 32'(valid_o), 32'd0);
        chk("c_bubble_grant", 32'(grant_o), 32'd0);
      end else if (c < 5) begin
        chk("c_g1", 32'(grant_o), 32'd1);
        chk("c_d1", 32'(data_o), 32'(flit(c - 1, 11)));
      end else if (c < 10) begin
        chk("c_g2", 32'(grant_o), 32'd2);
        chk("c_d2", 32'(data_o), 32'(flit(c - 6, 12)));
      end else begin
        chk("c_g3", 32'(grant_o), 32'd1);
        chk("c_d3", 32'(data_o), 32'(flit(c - 11, 13)));
      end
      step();
    end
    chk("c_cred", 32'(credit_cnt_o), 32'd4);

    // credit arithmetic: return, simultaneous cancel, saturation and error
    credit_upd_i = 1'b1;
    step();
    credit_upd_i = 1'b0;
    #1;
    chk("d_cred5", 32'(credit_cnt_o), 32'd5);
    push_c(4, 0, 3);
    step();
    credit_upd_i = 1'b1;
    #1;
    chk("d_valid", 32'(valid_o), 32'd1);
    step();
    credit_upd_i = 1'b0;
    #1;
    chk("d_cancel", 32'(credit_cnt_o), 32'd5);
    step(); step(); step();
    chk("d_cred2", 32'(credit_cnt_o), 32'd2);
    chk("d_idle", 32'(grant_o), 32'd0);
    credit_upd_i = 1'b1;
    for (int i = 0; i < 14; i++) step();
    credit_upd_i = 1'b0;
    #1;
    chk("d_full", 32'(credit_cnt_o), 32'd16);
    chk("d_noerr", 32'(credit_err_o), 32'd0);
    credit_upd_i = 1'b1;
    step();
    credit_upd_i = 1'b0;
    #1;
    chk("d_sat", 32'(credit_cnt_o), 32'd16);
    chk("d_err", 32'(credit_err_o), 32'd1);
    step();
    chk("d_err_sticky", 32'(credit_err_o), 32'd1);

    // occupancy gating of a partly buffered packet
    rstn = 1'b0;
    #1;
    chk("e_err_clr", 32'(credit_err_o), 32'd0);
    step();
    rstn = 1'b1;
    push_c(5, 0, 2);
    step(); step();
`ifdef NI_INJ_CUT_THROUGH_EN
    chk("e_ct_grant", 32'(grant_o), 32'd1);
`else
    chk("e_hold3", 32'(grant_o), 32'd0);
    push_c(5, 3, 3);
    chk("e_hold4", 32'(grant_o), 32'd0);
    step();
    chk("e_grant4", 32'(grant_o), 32'd1);
    chk("e_head", 32'(data_o), 32'(flit(0, 5)));
`endif

    // reset in the middle of a packet
    rstn = 1'b0;
    #1;
    cq.delete();
    drive();
    step();
    rstn = 1'b1;
    push_c(6, 0, 3);
    step(); step();
    chk("f_cred15", 32'(credit_cnt_o), 32'd15);
    chk("f_flit1", 32'(data_o), 32'(flit(1, 6)));
    rstn = 1'b0;
    #1;
    chk("f_rst_valid", 32'(valid_o), 32'd0);
    chk("f_rst_grant", 32'(grant_o), 32'd0);
    chk("f_rst_cred", 32'(credit_cnt_o), 32'd16);
    chk("f_rst_ready", 32'(c_ready_o), 32'd0);
    step();
    cq.delete();
    rstn = 1'b1;
    push_c(7, 0, 3);
    step();
    chk("f_regrant", 32'(grant_o), 32'd1);
    chk("f_rehead", 32'(data_o), 32'(flit(0, 7)));

    // two-credit instance: stall with grant held, resume after one return
    si = 0;
    s_c_valid = 1'b1;
    s_c_cnt = 8'd4;
    s_c_data = flit(0, 8);
    #1;
    step();
    chk("s_grant", 32'(s_grant), 32'd1);
    chk("s_cred2", 32'(s_cred), 32'd2);
    step();
    chk("s_valid1", 32'(s_valid), 32'd1);
    chk("s_data1", 32'(s_data), 32'(flit(1, 8)));
    step();
    chk("s_cred0", 32'(s_cred), 32'd0);
    chk("s_stall", 32'(s_valid), 32'd0);
    step();
    chk("s_stall2", 32'(s_valid), 32'd0);
    chk("s_hold", 32'(s_grant), 32'd1);
    s_upd = 1'b1;
    step();
    s_upd = 1'b0;
    #1;
    chk("s_cred1", 32'(s_cred), 32'd1);
    chk("s_resume", 32'(s_valid), 32'd1);
    chk("s_data2", 32'(s_data), 32'(flit(2, 8)));
    step();
    chk("s_data3", 32'(s_data), 32'(flit(3, 8)));
    chk("s_stall3", 32'(s_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
